cpu: RTL and testbench

Single-cycle 8-bit processor with a tiny 2×2 tensor (matrix-multiply) unit, driven one 32-bit instruction per clock from an external instruction source. It holds a 16-entry register file, executes scalar ALU, multiply-accumulate and 2×2 matrix-multiply instructions, and exposes results through a registered 8-bit output port. It is the top compute block of the tiny tensor core and is fed directly by the instruction stream.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/cpu_tensor_core_2x2.sv | 27 ++
 rtl/cpu.sv | 95 +++++++++
 tb/tb_cpu.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the single-cycle 8-bit tensor cpu.
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 16;

    // Instruction field bit positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int RD_HI  = 27;
    localparam int RD_LO  = 24;
    localparam int RS1_HI = 23;
    localparam int RS1_LO = 20;
    localparam int RS2_HI = 19;
    localparam int RS2_LO = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 8;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_LOADI  = 4'h1,
        OP_MOV    = 4'h2,
        OP_ADD    = 4'h3,
        OP_SUB    = 4'h4,
        OP_MUL    = 4'h5,
        OP_AND    = 4'h6,
        OP_OR     = 4'h7,
        OP_XOR    = 4'h8,
        OP_SHL    = 4'h9,
        OP_SHR    = 4'hA,
        OP_MAC    = 4'hB,
        OP_MATMUL = 4'hC,
        OP_OUT    = 4'hD
    } opcode_e;

endpackage

// File: rtl/cpu_tensor_core_2x2.sv
// Combinational 2x2 matrix multiply, C = A * B, every element wrapped to 8 bits.
module tensor_core_2x2
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a00,
    input  logic [DATA_W-1:0] a01,
    input  logic [DATA_W-1:0] a10,
    input  logic [DATA_W-1:0] a11,
    input  logic [DATA_W-1:0] b00,
    input  logic [DATA_W-1:0] b01,
    input  logic [DATA_W-1:0] b10,
    input  logic [DATA_W-1:0] b11,
    output logic [DATA_W-1:0] c00,
    output logic [DATA_W-1:0] c01,
    output logic [DATA_W-1:0] c10,
    output logic [DATA_W-1:0] c11
);

    // Dot products sized to DATA_W so the upper product bits fall away
    always_comb begin
        c00 = a00 * b00 + a01 * b10;
        c01 = a00 * b01 + a01 * b11;
        c10 = a10 * b00 + a11 * b10;
        c11 = a10 * b01 + a11 * b11;
    end

endmodule

// File: rtl/cpu.sv
// Single-cycle 8-bit cpu: register file, decode, scalar ALU, MAC, 2x2 matmul, output register.
module cpu
    import cpu_pkg::*;
(
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic [31:0]       current_instruction,
    output logic [DATA_W-1:0] cpu_output
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] out_d;

    opcode_e           opcode;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [DATA_W-1:0] imm8;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] mm_c00, mm_c01, mm_c10, mm_c11;
    logic              unused_reserved;

    assign opcode          = opcode_e'(current_instruction[OPC_HI:OPC_LO]);
    assign rd              = current_instruction[RD_HI:RD_LO];
    assign rs1             = current_instruction[RS1_HI:RS1_LO];
    assign rs2             = current_instruction[RS2_HI:RS2_LO];
    assign imm8            = current_instruction[IMM_HI:IMM_LO];
    assign unused_reserved = ^current_instruction[IMM_LO-1:0];

    assign op_a = regs_q[rs1];
    assign op_b = regs_q[rs2];

    tensor_core_2x2 u_tensor (
        .a00 (regs_q[0]),
        .a01 (regs_q[1]),
        .a10 (regs_q[2]),
        .a11 (regs_q[3]),
        .b00 (regs_q[4]),
        .b01 (regs_q[5]),
        .b10 (regs_q[6]),
        .b11 (regs_q[7]),
        .c00 (mm_c00),
        .c01 (mm_c01),
        .c10 (mm_c10),
        .c11 (mm_c11)
    );

    // Decode and execute; unmatched or unknown opcodes fall to the default and change nothing
    always_comb begin
        regs_d = regs_q;
        out_d  = out_q;
        case (opcode)
            OP_LOADI:  regs_d[rd] = imm8;
            OP_MOV:    regs_d[rd] = op_a;
            OP_ADD:    regs_d[rd] = op_a + op_b;
            OP_SUB:    regs_d[rd] = op_a - op_b;
            OP_MUL:    regs_d[rd] = op_a * op_b;
            OP_AND:    regs_d[rd] = op_a & op_b;
            OP_OR:     regs_d[rd] = op_a | op_b;
            OP_XOR:    regs_d[rd] = op_a ^ op_b;
            OP_SHL:    regs_d[rd] = op_a << imm8[2:0];
            OP_SHR:    regs_d[rd] = op_a >> imm8[2:0];
            OP_MAC:    regs_d[rd] = regs_q[rd] + op_a * op_b;
            OP_MATMUL: begin
                regs_d[8]  = mm_c00;
                regs_d[9]  = mm_c01;
                regs_d[10] = mm_c10;
                regs_d[11] = mm_c11;
            end
            OP_OUT:    out_d = op_a;
            default:   ;
        endcase
    end

    // State update; reset wins over whatever instruction is presented
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            out_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            out_q <= out_d;
        end
    end

    assign cpu_output = out_q;

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: stimulus pushes the expected cpu_output per cycle, a monitor pops and compares.
module tb_cpu;

    logic        clock_in;
    logic        reset_in;
    logic [31:0] current_instruction;
    logic [7:0]  cpu_output;

    cpu dut (
        .clock_in            (clock_in),
        .reset_in            (reset_in),
        .current_instruction (current_instruction),
        .cpu_output          (cpu_output)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    typedef struct {
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int m_regs [16];
    int m_out;

    function automatic logic [31:0] mk(input int op, input int rd, input int rs1,
                                       input int rs2, input int imm);
        logic [31:0] w;
        w = {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[7:0], 8'h00};
        return w;
    endfunction

    // Behavioural execution of one instruction from the opcode definitions
    task automatic model_exec(input logic [31:0] ins, input bit rst);
        int op, rd, a, b, imm;
        int old [16];
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            m_out = 0;
            return;
        end
        if ($isunknown(ins[31:28])) return;
        op  = int'(ins[31:28]);
        rd  = int'(ins[27:24]);
        old = m_regs;
        a   = old[int'(ins[23:20])];
        b   = old[int'(ins[19:16])];
        imm = int'(ins[15:8]);
        case (op)
            1:  m_regs[rd] = imm;
            2:  m_regs[rd] = a;
            3:  m_regs[rd] = (a + b) % 256;
            4:  m_regs[rd] = (a - b + 256) % 256;
            5:  m_regs[rd] = (a * b) % 256;
            6:  m_regs[rd] = a & b;
            7:  m_regs[rd] = a | b;
            8:  m_regs[rd] = a ^ b;
            9:  m_regs[rd] = (a * (1 << (imm % 8))) % 256;
            10: m_regs[rd] = a / (1 << (imm % 8));
            11: m_regs[rd] = (old[rd] + a * b) % 256;
            12: begin
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++) begin
                        int s;
                        s = 0;
                        for (int k = 0; k < 2; k++)
                            s += old[2*i + k] * old[4 + 2*k + j];
                        m_regs[8 + 2*i + j] = s % 256;
                    end
            end
            13: m_out = a;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [31:0] ins, input bit rst, input string tag);
        exp_t e;
        @(negedge clock_in);
        current_instruction = ins;
        reset_in            = rst;
        model_exec(ins, rst);
        e.val = m_out[7:0];
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: cpu_output is compared after every edge against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clock_in);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (cpu_output !== e.val) begin
                    bad++;
                    $display("FAIL %s: got %02h want %02h", e.tag, cpu_output, e.val);
                end
            end
        end
    end

    initial begin
        logic [31:0] xi;
        int waited;
        reset_in            = 1'b1;
        current_instruction = 32'h0;
        foreach (m_regs[i]) m_regs[i] = 0;
        m_out = 0;

        issue(32'h0, 1'b1, "reset0");

        // Reset after arbitrary writes
        for (int i = 0; i < 16; i++) issue(mk(1, i, 0, 0, $urandom_range(1, 255)), 0, "fill");
        issue(mk(13, 0, 5, 0, 0), 0, "pre_reset_out");
        issue(32'h0, 1'b1, "reset_clear");
        issue(mk(13, 0, 5, 0, 0), 0, "reset_out_r5");
        for (int i = 0; i < 16; i++) issue(mk(13, 0, i, 0, 0), 0, "reset_reg_zero");

        // Basic add and hold
        issue(mk(1, 1, 0, 0, 8'h05), 0, "loadi");
        issue(mk(1, 2, 0, 0, 8'h03), 0, "loadi");
        issue(mk(3, 3, 1, 2, 0), 0, "add");
        issue(mk(13, 0, 3, 0, 0), 0, "add_out");
        for (int i = 0; i < 3; i++) issue(32'h0, 0, "hold_nop");

        // Wrap behaviour
        issue(mk(1, 1, 0, 0, 8'hF0), 0, "loadi");
        issue(mk(1, 2, 0, 0, 8'h20), 0, "loadi");
        issue(mk(4, 4, 2, 1, 0), 0, "sub");
        issue(mk(5, 5, 1, 2, 0), 0, "mul");
        issue(mk(10, 6, 1, 0, 4), 0, "shr");
        issue(mk(13, 0, 4, 0, 0), 0, "sub_out");
        issue(mk(13, 0, 5, 0, 0), 0, "mul_out");
        issue(mk(13, 0, 6, 0, 0), 0, "shr_out");

        // MAC twice
        issue(mk(1, 7, 0, 0, 8'h02), 0, "loadi");
        issue(mk(1, 1, 0, 0, 8'h03), 0, "loadi");
        issue(mk(1, 2, 0, 0, 8'h04), 0, "loadi");
        issue(mk(11, 7, 1, 2, 0), 0, "mac1");
        issue(mk(13, 0, 7, 0, 0), 0, "mac1_out");
        issue(mk(11, 7, 1, 2, 0), 0, "mac2");
        issue(mk(13, 0, 7, 0, 0), 0, "mac2_out");

        // MATMUL
        for (int i = 0; i < 8; i++) issue(mk(1, i, 0, 0, i + 1), 0, "loadi");
        issue(mk(12, 15, 15, 15, 0), 0, "matmul");
        for (int i = 8; i < 12; i++) issue(mk(13, 0, i, 0, 0), 0, "matmul_out");

        // Back-to-back dependency and rd==rs operand aliasing
        issue(mk(1, 1, 0, 0, 9), 0, "loadi");
        issue(mk(13, 0, 1, 0, 0), 0, "b2b_out");
        issue(mk(3, 1, 1, 1, 0), 0, "add_self");
        issue(mk(13, 0, 1, 0, 0), 0, "add_self_out");

        // Reset in same cycle as LOADI
        issue(mk(1, 3, 0, 0, 8'h55), 1'b1, "reset_with_loadi");
        issue(mk(13, 0, 3, 0, 0), 0, "reset_loadi_out");

        // Unknown opcode is a NOP
        issue(mk(1, 4, 0, 0, 8'hA5), 0, "loadi");
        issue(mk(13, 0, 4, 0, 0), 0, "pre_x_out");
        xi = 32'hxxxxxxxx;
        xi[27:0] = 28'h4000000;
        issue(xi, 0, "x_instr");
        issue(mk(13, 0, 0, 0, 0), 0, "x_out_r0");
        issue(mk(13, 0, 4, 0, 0), 0, "x_out_r4");

        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            issue(mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 255)), 0, "rand");
            if ($urandom_range(0, 3) == 0)
                issue(mk(13, 0, $urandom_range(0, 15), 0, 0), 0, "rand_out");
        end
        for (int i = 0; i < 16; i++) issue(mk(13, 0, i, 0, 0), 0, "final_dump");

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clock_in);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
